// File: rtl/ser_tx_scheduler.sv
// Round-robin scheduler feeding one 32-to-8 serializer from N_REQ word sources,
// with watchdog abort and optional idle/comma word insertion.
module ser_tx_scheduler #(
    parameter int          N_REQ     = 4,
    parameter int          DATA_W    = 32,
    parameter int          TIMEOUT   = 15,
    parameter bit          IDLE_EN   = 1'b1,
    parameter logic [31:0] IDLE_WORD = 32'hBCBC_BCBC
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_W-1:0]     req_data,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        ser_load,
    output logic [DATA_W-1:0]           ser_din,
    input  logic                        ser_done,
    output logic                        busy,
    output logic [$clog2(N_REQ)-1:0]    grant_id,
    output logic                        idle_sent,
    output logic                        timeout_err,
    output logic [15:0]                 word_cnt
);
    localparam int ID_W = $clog2(N_REQ);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic [DATA_W-1:0]  ser_din_q, ser_din_d;
    logic               idle_sent_q, idle_sent_d;
    logic               timeout_err_q, timeout_err_d;
    logic [15:0]        word_cnt_q, word_cnt_d;
    logic [WD_W-1:0]    wd_q, wd_d;

    logic               found;
    logic [ID_W-1:0]    gnt;
    logic [ID_W-1:0]    cand;
    int                 arb_idx;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        found   = 1'b0;
        gnt     = '0;
        cand    = '0;
        arb_idx = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            arb_idx = (int'(ptr_q) + k) % N_REQ;
            cand    = ID_W'(arb_idx);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                gnt   = cand;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_id_d    = grant_id_q;
        ser_din_d     = ser_din_q;
        idle_sent_d   = idle_sent_q;
        word_cnt_d    = word_cnt_q;
        wd_d          = wd_q;
        timeout_err_d = 1'b0;
        req_ready     = '0;
        ser_load      = 1'b0;
        busy          = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    if (found) begin
                        req_ready[gnt] = 1'b1;
                        ser_din_d      = req_data[gnt*DATA_W +: DATA_W];
                        grant_id_d     = gnt;
                        ptr_d          = gnt;
                        idle_sent_d    = 1'b0;
                        state_d        = LOAD;
                    end else if (IDLE_EN) begin
                        ser_din_d   = IDLE_WORD;
                        idle_sent_d = 1'b1;
                        state_d     = LOAD;
                    end
                end
            end
            LOAD: begin
                ser_load = 1'b1;
                busy     = 1'b1;
                wd_d     = '0;
                state_d  = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                wd_d = wd_q + 1'b1;
                // wd_q == 0 is the first WAIT cycle: a done there belongs to the previous word.
                if (ser_done && (wd_q != '0)) begin
                    state_d = IDLE;
                    if (!idle_sent_q) word_cnt_d = word_cnt_q + 16'd1;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= ID_W'(N_REQ - 1);
            grant_id_q    <= '0;
            ser_din_q     <= '0;
            idle_sent_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            word_cnt_q    <= '0;
            wd_q          <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_id_q    <= grant_id_d;
            ser_din_q     <= ser_din_d;
            idle_sent_q   <= idle_sent_d;
            timeout_err_q <= timeout_err_d;
            word_cnt_q    <= word_cnt_d;
            wd_q          <= wd_d;
        end
    end

    assign ser_din     = ser_din_q;
    assign grant_id    = grant_id_q;
    assign idle_sent   = idle_sent_q;
    assign timeout_err = timeout_err_q;
    assign word_cnt    = word_cnt_q;
endmodule

// File: tb/tb_ser_tx_scheduler.sv
// Directed bench for ser_tx_scheduler: serializer model with done 5 cycles after load,
// expected words queued at accept time and checked when the load strobe appears.
module tb_ser_tx_scheduler;
  localparam logic [31:0] IDLE_W = 32'hBCBC_BCBC;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [127:0] req_data = '0;
  logic [3:0]   req_ready;
  logic         ser_load;
  logic [31:0]  ser_din;
  logic         ser_done;
  logic         busy;
  logic [1:0]   grant_id;
  logic         idle_sent;
  logic         timeout_err;
  logic [15:0]  word_cnt;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int dcnt = 0;
  logic done_en = 1'b1;
  logic [32:0] exp_q[$];
  logic [31:0] words[4];
  int load_t[8];

  ser_tx_scheduler dut (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .ser_load(ser_load), .ser_din(ser_din), .ser_done(ser_done),
    .busy(busy), .grant_id(grant_id), .idle_sent(idle_sent), .timeout_err(timeout_err),
    .word_cnt(word_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // serializer model: done pulse in the 5th cycle after the load cycle
  always @(posedge clk or posedge rst) begin
    if (rst) dcnt <= 0;
    else if (ser_load) dcnt <= 1;
    else if (dcnt != 0 && dcnt < 100) dcnt <= dcnt + 1;
  end
  assign ser_done = done_en && (dcnt == 5);

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // scoreboard: every load strobe must match the oldest queued word
  always @(negedge clk) begin
    if (!rst && ser_load) begin
      if (exp_q.size() == 0) chk("load_unexpected", 33'(ser_din), 33'h1_DEAD_0000);
      else chk("load_word", {idle_sent, ser_din}, exp_q.pop_front());
    end
    if (!rst && req_ready != 0) chk("ready_onehot", 33'($onehot(req_ready)), 33'd1);
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", 33'(busy), 33'd0);
  endtask

  // Grant exactly one word: en high for a single IDLE cycle.
  task automatic send_one(input logic [3:0] vmask, input int gid);
    req_valid = vmask;
    en = 1'b1;
    #1;
    chk("accept_ready", 33'(req_ready), 33'(4'b0001 << gid));
    exp_q.push_back({1'b0, words[gid]});
    @(negedge clk);
    en = 1'b0;
    chk("load_busy", 33'(busy), 33'd1);
    chk("load_gid", 33'(grant_id), 33'(gid));
  endtask

  initial begin
    int n;
    int c0;
    logic [15:0] wc;
    for (int i = 0; i < 4; i++) begin
      words[i] = (i == 0) ? 32'hDEAD_BEEF : $urandom_range(32'h7FFF_FFFF, 1);
      req_data[i*32 +: 32] = words[i];
    end

    // reset values
    rst = 1'b1;
    #12;
    chk("rst_ser_load", 33'(ser_load), 33'd0);
    chk("rst_ser_din", 33'(ser_din), 33'd0);
    chk("rst_busy", 33'(busy), 33'd0);
    chk("rst_grant_id", 33'(grant_id), 33'd0);
    chk("rst_idle_sent", 33'(idle_sent), 33'd0);
    chk("rst_timeout", 33'(timeout_err), 33'd0);
    chk("rst_word_cnt", 33'(word_cnt), 33'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: single source
    send_one(4'b0001, 0);
    wait_idle();
    chk("t1_word_cnt", 33'(word_cnt), 33'd1);
    chk("t1_grant_id", 33'(grant_id), 33'd0);

    // 2: round robin with back-to-back throughput
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, words[i % 4]});
    req_valid = 4'hF;
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!ser_load && n < 20);
      chk("t2_load_seen", 33'(ser_load), 33'd1);
      chk("t2_gid", 33'(grant_id), 33'(i % 4));
      load_t[i] = cyc;
      if (i == 7) en = 1'b0;
    end
    for (int i = 1; i < 8; i++) chk("t2_interval", 33'(load_t[i] - load_t[i-1]), 33'd7);
    wait_idle();
    chk("t2_word_cnt", 33'(word_cnt), 33'd8);

    // 3: idle insertion, then requester 2
    req_valid = 4'b0000;
    en = 1'b1;
    #1;
    chk("t3_no_ready", 33'(req_ready), 33'd0);
    exp_q.push_back({1'b1, IDLE_W});
    @(negedge clk);
    en = 1'b0;
    chk("t3_idle_sent", 33'(idle_sent), 33'd1);
    chk("t3_idle_din", 33'(ser_din), 33'(IDLE_W));
    chk("t3_gid_kept", 33'(grant_id), 33'd3);
    wait_idle();
    chk("t3_word_cnt", 33'(word_cnt), 33'd8);
    send_one(4'b0100, 2);
    chk("t3_real_word", 33'(idle_sent), 33'd0);
    wait_idle();
    chk("t3_word_cnt2", 33'(word_cnt), 33'd9);

    // 4: watchdog
    done_en = 1'b0;
    send_one(4'b0001, 0);
    c0 = cyc;
    n = 0;
    while (!timeout_err && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("t4_timeout_seen", 33'(timeout_err), 33'd1);
    chk("t4_timeout_cycles", 33'(cyc - c0), 33'd16);
    chk("t4_busy", 33'(busy), 33'd0);
    chk("t4_word_cnt", 33'(word_cnt), 33'd9);
    @(negedge clk);
    chk("t4_pulse_width", 33'(timeout_err), 33'd0);
    done_en = 1'b1;
    send_one(4'b0001, 0);
    wait_idle();
    chk("t4_word_cnt2", 33'(word_cnt), 33'd10);
    chk("t4_no_timeout", 33'(timeout_err), 33'd0);

    // 5: reset mid-word
    send_one(4'b0010, 1);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_ser_load", 33'(ser_load), 33'd0);
    chk("t5_busy", 33'(busy), 33'd0);
    chk("t5_word_cnt", 33'(word_cnt), 33'd0);
    chk("t5_timeout", 33'(timeout_err), 33'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_one(4'b1111, 0);
    wait_idle();
    chk("t5_word_cnt2", 33'(word_cnt), 33'd1);

    // 6: enable dropped during WAIT, then counter wrap
    req_valid = 4'hF;
    en = 1'b1;
    #1;
    chk("t6_ready", 33'(req_ready), 33'd2);
    exp_q.push_back({1'b0, words[1]});
    @(negedge clk);
    @(negedge clk);
    en = 1'b0;
    wait_idle();
    chk("t6_word_cnt", 33'(word_cnt), 33'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_gated_ready", 33'({busy, req_ready}), 33'd0);
    end
    force dut.word_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.word_cnt_q;
    @(negedge clk);
    wc = word_cnt;
    chk("t6_preload", 33'(wc), 33'h0FFFF);
    send_one(4'b1111, 2);
    wait_idle();
    chk("t6_wrap", 33'(word_cnt), 33'd0);

    repeat (3) @(negedge clk);
    chk("queue_empty", 33'(exp_q.size()), 33'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end
endmodule
